// File: rtl/mips_mem_pkg.sv
// Shared constants and port-select encoding for the MIPS unified memory arbiter.
package mips_mem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_IF   = 2'd1,
    PORT_D_RD = 2'd2
  } port_sel_e;

  // Only reads need a return path; a granted store collapses to PORT_NONE.
  function automatic port_sel_e sel_of(logic if_g, logic d_g, logic d_we);
    if (if_g)             return PORT_IF;
    else if (d_g && !d_we) return PORT_D_RD;
    else                  return PORT_NONE;
  endfunction

endpackage

// File: rtl/mips_starve_ctr.sv
// Saturating starvation counter for the fetch port; at_max_o flags that IF must win next.
module mips_starve_ctr
  import mips_mem_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (inc_i && cnt_q != W'(MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_FAIR_EN to bound fetch starvation to STARVE_MAX denied cycles.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = mips_mem_pkg::ADDR_W,
  parameter int DATA_W     = mips_mem_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic force_if;

`ifdef MEM_ARB_FAIR_EN
  logic starve_at_max;

  mips_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .inc_i    (if_req & ~if_gnt & ~halt),
    .clr_i    (if_gnt | ~if_req),
    .at_max_o (starve_at_max)
  );

  assign force_if = starve_at_max & if_req & ~halt;
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
  assign force_if          = 1'b0;
`endif

  port_sel_e          sel_q, sel_d;
  logic [DATA_W-1:0]  if_rdata_q, d_rdata_q;

  // Grants are combinational but held off while reset is asserted.
  always_comb begin
    d_gnt  = RST_N & d_req & ~force_if;
    if_gnt = RST_N & if_req & ~halt & (~d_req | force_if);
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign sel_d = sel_of(if_gnt, d_gnt, d_we);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q      <= PORT_NONE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      sel_q <= sel_d;
      if (sel_q == PORT_IF)   if_rdata_q <= mem_rdata;
      if (sel_q == PORT_D_RD) d_rdata_q  <= mem_rdata;
    end
  end

  // Read data passes straight through in the return cycle, then is held.
  assign if_rvalid = (sel_q == PORT_IF);
  assign d_rvalid  = (sel_q == PORT_D_RD);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus a randomized run
// against a port-level reference model with a shadow memory.
module tb_mips_mem_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int STARVE_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt = 1'b0;
  logic [9:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  int checks = 0;
  int errors = 0;

  mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .halt(halt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Single-port synchronous memory
  logic [31:0] mem [0:1023];
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic drive(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                       input logic [9:0] da, input logic [31:0] dd, input logic h);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; halt = h;
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    #1 RST_N = 1'b0;
    drive(1'b1, 10'd5, 1'b1, 1'b0, 10'd7, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt if=%b d=%b exp 0 0", if_gnt, d_gnt); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== 10'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem en=%b addr=%h we=%b exp 0", mem_en, mem_addr, mem_we); end
    checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid if=%b d=%b exp 0 0", if_rvalid, d_rvalid); end
    checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata if=%h d=%h exp 0 0", if_rdata, d_rdata); end
    tick();
    RST_N = 1'b1;
    drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'h2001000A, 1'b0);
    @(negedge CLK);
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'd5 || mem_wdata !== 32'h2001000A) begin
      errors++; $display("FAIL first_grant d_gnt=%b we=%b addr=%h wdata=%h exp 1 1 005 2001000a", d_gnt, mem_we, mem_addr, mem_wdata); end
    tick();
  endtask

  task automatic test_if_read;
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5) begin
      errors++; $display("FAIL if_grant gnt=%b dgnt=%b en=%b we=%b addr=%h exp 1 0 1 0 005", if_gnt, d_gnt, mem_en, mem_we, mem_addr); end
    tick();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2001000A || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL if_rdata rv=%b data=%h drv=%b exp 1 2001000a 0", if_rvalid, if_rdata, d_rvalid); end
    tick();
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h2001000A) begin
      errors++; $display("FAIL if_hold rv=%b data=%h exp 0 2001000a", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_conflict;
    drive(1'b0, 10'd0, 1'b1, 1'b1, 10'h100, 32'h55, 1'b0);
    tick();
    drive(1'b1, 10'd5, 1'b1, 1'b0, 10'h100, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 10'h100) begin
      errors++; $display("FAIL conflict_gnt d=%b if=%b addr=%h exp 1 0 100", d_gnt, if_gnt, mem_addr); end
    tick();
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h55 || if_gnt !== 1'b1) begin
      errors++; $display("FAIL conflict_load drv=%b data=%h ifgnt=%b exp 1 55 1", d_rvalid, d_rdata, if_gnt); end
    tick();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2001000A || d_rvalid !== 1'b0 || d_rdata !== 32'h55) begin
      errors++; $display("FAIL conflict_if irv=%b idata=%h drv=%b ddata=%h exp 1 2001000a 0 55", if_rvalid, if_rdata, d_rvalid, d_rdata); end
    tick();
  endtask

  task automatic test_store_load;
    drive(1'b0, 10'd0, 1'b1, 1'b1, 10'h120, 32'hDEAD, 1'b0);
    @(negedge CLK);
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD) begin
      errors++; $display("FAIL store gnt=%b we=%b wdata=%h exp 1 1 dead", d_gnt, mem_we, mem_wdata); end
    tick();
    drive(1'b0, 10'd0, 1'b1, 1'b0, 10'h120, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_gnt !== 1'b1) begin
      errors++; $display("FAIL store_no_rvalid drv=%b irv=%b gnt=%b exp 0 0 1", d_rvalid, if_rvalid, d_gnt); end
    tick();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD) begin
      errors++; $display("FAIL load_after_store rv=%b data=%h exp 1 dead", d_rvalid, d_rdata); end
    tick();
  endtask

  task automatic test_starve;
    int n_if = 0;
    tick();
    for (int k = 0; k < 10; k++) begin
      logic ir, exp_if;
      ir     = FAIR ? (k <= 4) : 1'b1;
      exp_if = FAIR && (k == 4);
      drive(ir, 10'd5, 1'b1, 1'b0, 10'h100, 32'h0, 1'b0);
      @(negedge CLK);
      if (if_gnt === 1'b1) n_if++;
      checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin
        errors++; $display("FAIL starve_cyc%0d if=%b d=%b exp %b %b", k + 1, if_gnt, d_gnt, exp_if, !exp_if); end
      tick();
    end
    checks++; if (n_if != (FAIR ? 1 : 0)) begin
      errors++; $display("FAIL starve_count if_gnts=%0d exp %0d", n_if, FAIR ? 1 : 0); end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_halt;
    drive(1'b1, 10'd5, 1'b1, 1'b0, 10'h120, 32'h0, 1'b1);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b1) begin
      errors++; $display("FAIL halt_gnt if=%b d=%b exp 0 1", if_gnt, d_gnt); end
    tick();
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b0 || mem_en !== 1'b0 || d_rvalid !== 1'b1 || d_rdata !== 32'hDEAD) begin
      errors++; $display("FAIL halt_block ifgnt=%b en=%b drv=%b data=%h exp 0 0 1 dead", if_gnt, mem_en, d_rvalid, d_rdata); end
    tick();
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL halt_release ifgnt=%b exp 1", if_gnt); end
    tick();
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0, 1'b1);
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2001000A || if_gnt !== 1'b0) begin
      errors++; $display("FAIL halt_outstanding rv=%b data=%h gnt=%b exp 1 2001000a 0", if_rvalid, if_rdata, if_gnt); end
    tick();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 10'd5, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt ifgnt=%b exp 1", if_gnt); end
    tick();
    RST_N = 1'b0;
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_out rv=%b idata=%h ddata=%h gnt=%b en=%b exp 0 0 0 0 0", if_rvalid, if_rdata, d_rdata, if_gnt, mem_en); end
    tick();
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b0 || if_gnt !== 1'b1) begin
      errors++; $display("FAIL rstmid_release rv=%b gnt=%b exp 0 1", if_rvalid, if_gnt); end
    tick();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h2001000A) begin
      errors++; $display("FAIL rstmid_read rv=%b data=%h exp 1 2001000a", if_rvalid, if_rdata); end
    tick();
  endtask

  task automatic test_random;
    logic [31:0] ref_mem [16];
    logic        pend_if = 1'b0, pend_d = 1'b0;
    logic [31:0] pend_if_data = '0, pend_d_data = '0;
    logic [31:0] if_hold = 32'h2001000A, d_hold = 32'h0;
    int          cnt = 0;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      drive(1'b0, 10'd0, 1'b1, 1'b1, 10'(a), ref_mem[a], 1'b0);
      @(negedge CLK);
      checks++; if (d_gnt !== 1'b1 || mem_addr !== 10'(a)) begin
        errors++; $display("FAIL rnd_prewrite%0d gnt=%b addr=%h", a, d_gnt, mem_addr); end
      tick();
    end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tick();
    for (int c = 0; c < 400; c++) begin
      logic ir, dr, dw, h, frc, e_if, e_d;
      logic [9:0]  ia, da, e_addr;
      logic [31:0] dd;
      ir = 1'($urandom_range(0, 1));
      dr = ($urandom_range(0, 3) != 0);
      dw = ($urandom_range(0, 2) == 0);
      h  = ($urandom_range(0, 7) == 0);
      ia = 10'($urandom_range(0, 15));
      da = 10'($urandom_range(0, 15));
      dd = $urandom;
      drive(ir, ia, dr, dw, da, dd, h);
      @(negedge CLK);
      frc    = FAIR && (cnt >= STARVE_MAX) && ir && !h;
      e_if   = ir && !h && (!dr || frc);
      e_d    = dr && !frc;
      e_addr = e_d ? da : (e_if ? ia : 10'd0);
      if (pend_if) if_hold = pend_if_data;
      if (pend_d)  d_hold  = pend_d_data;
      checks++; if (if_gnt !== e_if || d_gnt !== e_d) begin
        errors++; $display("FAIL rnd%0d_gnt if=%b d=%b exp %b %b", c, if_gnt, d_gnt, e_if, e_d); end
      checks++; if (mem_en !== (e_if || e_d) || mem_we !== (e_d && dw) || mem_addr !== e_addr) begin
        errors++; $display("FAIL rnd%0d_mem en=%b we=%b addr=%h exp %b %b %h", c, mem_en, mem_we, mem_addr, e_if || e_d, e_d && dw, e_addr); end
      checks++; if (if_rvalid !== pend_if || if_rdata !== if_hold) begin
        errors++; $display("FAIL rnd%0d_if rv=%b data=%h exp %b %h", c, if_rvalid, if_rdata, pend_if, if_hold); end
      checks++; if (d_rvalid !== pend_d || d_rdata !== d_hold) begin
        errors++; $display("FAIL rnd%0d_d rv=%b data=%h exp %b %h", c, d_rvalid, d_rdata, pend_d, d_hold); end
      pend_if = e_if;
      if (e_if) pend_if_data = ref_mem[ia[3:0]];
      pend_d = e_d && !dw;
      if (pend_d) pend_d_data = ref_mem[da[3:0]];
      if (e_d && dw) ref_mem[da[3:0]] = dd;
      if (e_if || !ir)  cnt = 0;
      else if (!h)      cnt = (cnt < STARVE_MAX) ? cnt + 1 : cnt;
      tick();
    end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_conflict();
    test_store_load();
    test_starve();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
